speck_hash_controller: RTL and testbench

Sequencing FSM for the SPECK hash datapath: drives its counter resets, register clear, input/hash mux selects and result-memory strobes through one full hash job. Sits between the system-side start/done handshake and the datapath. Consumes the datapath's `eqz4_9`, `eqz2_0`, `eqz4_1` flags. The hash nibbles reach the RC4 stage through the datapath's `hout` during the read-out phase.

---
 rtl/speck_hash_controller_pkg.sv | 85 ++++++++
 rtl/speck_hash_controller_phase_counter.sv | 44 ++++
 rtl/speck_hash_controller.sv | 164 ++++++++++++++++
 tb/tb_speck_hash_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_hash_controller_pkg.sv
// ----------------------------------------------------------------------------
// speck_ctrl_pkg: state encoding, defaults and output decode for the SPECK hash controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package speck_ctrl_pkg;

  localparam int PHASE_W       = 5;
  localparam int STATE_W       = 4;
  localparam int DEF_WR_CYCLES = 16;
  localparam int DEF_RD_CYCLES = 16;
  localparam int DEF_TIMEOUT   = 31;

  localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] ST_CLR   = 4'd1;
  localparam logic [STATE_W-1:0] ST_LOAD  = 4'd2;
  localparam logic [STATE_W-1:0] ST_ROUND = 4'd3;
  localparam logic [STATE_W-1:0] ST_HLOAD = 4'd4;
  localparam logic [STATE_W-1:0] ST_HASH  = 4'd5;
  localparam logic [STATE_W-1:0] ST_WRITE = 4'd6;
  localparam logic [STATE_W-1:0] ST_RWIND = 4'd7;
  localparam logic [STATE_W-1:0] ST_READ  = 4'd8;
  localparam logic [STATE_W-1:0] ST_DONE  = 4'd9;
  localparam logic [STATE_W-1:0] ST_ERR   = 4'd10;

  typedef struct packed {
    logic reset8;
    logic reset4;
    logic reset_reg;
    logic reset_counter;
    logic ld;
    logic ld1;
    logic wr;
    logic rd;
    logic en;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Moore decode; unused encodings behave like IDLE (all datapath clears held)
  function automatic ctrl_out_t ctrl_decode(input logic [STATE_W-1:0] st);
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_CLR: begin
        o.reset8 = 1'b1; o.reset4 = 1'b1; o.reset_reg = 1'b1; o.reset_counter = 1'b1;
        o.busy = 1'b1;
      end
      ST_LOAD: begin
        o.reset_counter = 1'b1; o.ld = 1'b1; o.ld1 = 1'b1; o.busy = 1'b1;
      end
      ST_ROUND: begin
        o.ld1 = 1'b1; o.busy = 1'b1;
      end
      ST_HLOAD: begin
        o.reset4 = 1'b1; o.ld1 = 1'b1; o.busy = 1'b1;
      end
      ST_HASH: o.busy = 1'b1;
      ST_WRITE: begin
        o.wr = 1'b1; o.en = 1'b1; o.busy = 1'b1;
      end
      ST_RWIND: begin
        o.reset_counter = 1'b1; o.busy = 1'b1;
      end
      ST_READ: begin
        o.rd = 1'b1; o.en = 1'b1; o.busy = 1'b1;
      end
      ST_DONE: begin
        o.done = 1'b1; o.busy = 1'b1;
      end
      ST_ERR: begin
        o.reset8 = 1'b1; o.reset4 = 1'b1; o.reset_reg = 1'b1; o.reset_counter = 1'b1;
        o.done = 1'b1;
      end
      default: begin
        o.reset8 = 1'b1; o.reset4 = 1'b1; o.reset_reg = 1'b1; o.reset_counter = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/speck_hash_controller_phase_counter.sv
// ----------------------------------------------------------------------------
// speck_ctrl_phase_counter: loadable down counter that saturates at zero.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module speck_ctrl_phase_counter
  import speck_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_value,
  input  logic               dec,
  output logic [PHASE_W-1:0] value,
  output logic               zero
);

  logic [PHASE_W-1:0] value_q;
  logic [PHASE_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (dec && (value_q != '0)) begin
      value_d = value_q - PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

`default_nettype wire

// File: rtl/speck_hash_controller.sv
// ----------------------------------------------------------------------------
// speck_hash_controller: sequences one SPECK hash job; SPECK_CTRL_WATCHDOG_EN adds a ROUND/HASH timeout.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module speck_hash_controller
  import speck_ctrl_pkg::*;
#(
  parameter int WR_CYCLES = DEF_WR_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES
`ifdef SPECK_CTRL_WATCHDOG_EN
  , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic eqz4_9,
  input  logic eqz2_0,
  input  logic eqz4_1,
  output logic reset8,
  output logic reset4,
  output logic reset_reg,
  output logic reset_counter,
  output logic ld,
  output logic ld1,
  output logic wr,
  output logic rd,
  output logic en,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [PHASE_W-1:0] WR_LD      = PHASE_W'(WR_CYCLES);
  localparam logic [PHASE_W-1:0] RD_LD      = PHASE_W'(RD_CYCLES);
  localparam logic [PHASE_W-1:0] WR_2ND     = PHASE_W'(WR_CYCLES - 1);
  localparam bit                 ADDR_CHECK = (WR_CYCLES > 1);
`ifdef SPECK_CTRL_WATCHDOG_EN
  localparam logic [PHASE_W-1:0] TIMEOUT_LD = PHASE_W'(TIMEOUT);
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic               err_q, err_d;
  logic               ph_load, ph_dec, ph_zero, phase_end, addr_fail;
  logic [PHASE_W-1:0] ph_load_val, ph_value;
  ctrl_out_t          ctrl;

  speck_ctrl_phase_counter u_phase (
    .clk        (clk),
    .rst_n      (reset),
    .load       (ph_load),
    .load_value (ph_load_val),
    .dec        (ph_dec),
    .value      (ph_value),
    .zero       (ph_zero)
  );

  // Zero is treated as an end too, so a phase can never stall on a wrapped count
  assign phase_end = (ph_value == PHASE_W'(1)) || ph_zero;
  assign addr_fail = ADDR_CHECK && (ph_value == WR_2ND) && !eqz4_1;

  always_comb begin
    state_d     = state_q;
    ph_load     = 1'b0;
    ph_load_val = '0;
    ph_dec      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR:  state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_ROUND;
`ifdef SPECK_CTRL_WATCHDOG_EN
        ph_load     = 1'b1;
        ph_load_val = TIMEOUT_LD;
`endif
      end
      ST_ROUND: begin
`ifdef SPECK_CTRL_WATCHDOG_EN
        ph_dec = 1'b1;
        if (eqz4_9) state_d = ST_HLOAD;
        else if (phase_end) state_d = ST_ERR;
`else
        if (eqz4_9) state_d = ST_HLOAD;
`endif
      end
      ST_HLOAD: begin
        state_d = ST_HASH;
`ifdef SPECK_CTRL_WATCHDOG_EN
        ph_load     = 1'b1;
        ph_load_val = TIMEOUT_LD;
`endif
      end
      ST_HASH: begin
        if (eqz2_0) begin
          state_d     = ST_WRITE;
          ph_load     = 1'b1;
          ph_load_val = WR_LD;
        end
`ifdef SPECK_CTRL_WATCHDOG_EN
        else begin
          ph_dec = 1'b1;
          if (phase_end) state_d = ST_ERR;
        end
`else
`endif
      end
      ST_WRITE: begin
        ph_dec = 1'b1;
        if (addr_fail) state_d = ST_ERR;
        else if (phase_end) state_d = ST_RWIND;
      end
      ST_RWIND: begin
        state_d     = ST_READ;
        ph_load     = 1'b1;
        ph_load_val = RD_LD;
      end
      ST_READ: begin
        ph_dec = 1'b1;
        if (phase_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end else if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign ctrl          = ctrl_decode(state_q);
  assign reset8        = ctrl.reset8;
  assign reset4        = ctrl.reset4;
  assign reset_reg     = ctrl.reset_reg;
  assign reset_counter = ctrl.reset_counter;
  assign ld            = ctrl.ld;
  assign ld1           = ctrl.ld1;
  assign wr            = ctrl.wr;
  assign rd            = ctrl.rd;
  assign en            = ctrl.en;
  assign busy          = ctrl.busy;
  assign done          = ctrl.done;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_speck_hash_controller.sv
// ----------------------------------------------------------------------------
// tb_speck_hash_controller: directed bench for the default build and a WR/RD=1 instance.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_speck_hash_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, eqz4_9 = 1'b0, eqz2_0 = 1'b0, eqz4_1 = 1'b0;
  logic reset8, reset4, reset_reg, reset_counter, ld, ld1, wr, rd, en, busy, done, err;
  logic start_b = 1'b0, eqz4_9_b = 1'b0, eqz2_0_b = 1'b0, eqz4_1_b = 1'b0;
  logic reset8_b, reset4_b, reset_reg_b, reset_counter_b, ld_b, ld1_b;
  logic wr_b, rd_b, en_b, busy_b, done_b, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  speck_hash_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .eqz4_9(eqz4_9), .eqz2_0(eqz2_0), .eqz4_1(eqz4_1),
    .reset8(reset8), .reset4(reset4), .reset_reg(reset_reg), .reset_counter(reset_counter),
    .ld(ld), .ld1(ld1), .wr(wr), .rd(rd), .en(en), .busy(busy), .done(done), .err(err)
  );

  speck_hash_controller #(.WR_CYCLES(1), .RD_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .eqz4_9(eqz4_9_b), .eqz2_0(eqz2_0_b), .eqz4_1(eqz4_1_b),
    .reset8(reset8_b), .reset4(reset4_b), .reset_reg(reset_reg_b), .reset_counter(reset_counter_b),
    .ld(ld_b), .ld1(ld1_b), .wr(wr_b), .rd(rd_b), .en(en_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 0; eqz4_9 = 0; eqz2_0 = 0; eqz4_1 = 0;
    reset = 0;
    #1;
    tick;
    reset = 1;
    tick;
  endtask

  task automatic test_reset;
    #2 reset = 0;
    #1;
    checks++;
    if ({reset8, reset4, reset_reg, reset_counter} !== 4'hF) begin
      errors++; $display("FAIL reset_clears: got %b want 1111", {reset8, reset4, reset_reg, reset_counter});
    end
    checks++;
    if ({ld, ld1, wr, rd, en, busy, done, err} !== 8'h00) begin
      errors++; $display("FAIL reset_others: got %b want 00000000", {ld, ld1, wr, rd, en, busy, done, err});
    end
    checks++;
    if ({reset8_b, reset4_b, reset_reg_b, reset_counter_b, busy_b, done_b, err_b} !== 7'b1111000) begin
      errors++; $display("FAIL reset_dut_b: got %b want 1111000",
                         {reset8_b, reset4_b, reset_reg_b, reset_counter_b, busy_b, done_b, err_b});
    end
    tick;
    reset = 1;
    tick;
    tick;
    checks++;
    if ({reset8, reset4, reset_reg, reset_counter, busy} !== 5'b11110) begin
      errors++; $display("FAIL idle_after_reset: got %b want 11110", {reset8, reset4, reset_reg, reset_counter, busy});
    end
  endtask

  task automatic test_nominal;
    int wr_n = 0, rd_n = 0, en_n = 0, ovl = 0, done_k = -1, first_wr = -1, first_rd = -1;
    start = 1;
    tick;
    start = 0;
    checks++;
    if ({busy, reset8, reset4, reset_reg, reset_counter, ld} !== 6'b111110) begin
      errors++; $display("FAIL clr_state: got %b want 111110", {busy, reset8, reset4, reset_reg, reset_counter, ld});
    end
    for (int k = 1; k <= 50; k++) begin
      eqz4_9 = (k == 11); eqz2_0 = (k == 15); eqz4_1 = (k == 17);
      tick;
      if (wr) begin wr_n++; if (first_wr < 0) first_wr = k; end
      if (rd) begin rd_n++; if (first_rd < 0) first_rd = k; end
      if (en) en_n++;
      if (wr && rd) ovl++;
      if (done && done_k < 0) done_k = k;
      if (k == 1) begin
        checks++;
        if ({reset8, reset4, reset_reg, reset_counter, ld, ld1} !== 6'b000111) begin
          errors++; $display("FAIL load_state: got %b want 000111", {reset8, reset4, reset_reg, reset_counter, ld, ld1});
        end
      end
      if (k == 11) begin
        checks++;
        if ({reset8, reset4, reset_reg, reset_counter, ld, ld1} !== 6'b010001) begin
          errors++; $display("FAIL hload_state: got %b want 010001", {reset8, reset4, reset_reg, reset_counter, ld, ld1});
        end
      end
      if (k == 12) begin
        checks++;
        if ({reset4, ld1, busy, wr} !== 4'b0010) begin
          errors++; $display("FAIL hash_state: got %b want 0010", {reset4, ld1, busy, wr});
        end
      end
      if (k == 31) begin
        checks++;
        if ({reset_counter, wr, rd, en, busy} !== 5'b10001) begin
          errors++; $display("FAIL rwind_state: got %b want 10001", {reset_counter, wr, rd, en, busy});
        end
      end
    end
    eqz4_9 = 0; eqz2_0 = 0; eqz4_1 = 0;
    checks++;
    if (done_k !== 48) begin errors++; $display("FAIL nominal_latency: got %0d want 48", done_k); end
    checks++;
    if (wr_n !== 16 || rd_n !== 16 || en_n !== 32) begin
      errors++; $display("FAIL strobe_counts: got wr=%0d rd=%0d en=%0d want 16 16 32", wr_n, rd_n, en_n);
    end
    checks++;
    if (first_wr !== 15 || first_rd !== 32) begin
      errors++; $display("FAIL strobe_start: got wr@%0d rd@%0d want 15 32", first_wr, first_rd);
    end
    checks++;
    if (ovl !== 0) begin errors++; $display("FAIL wr_rd_overlap: got %0d want 0", ovl); end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL nominal_end: got %b want 000", {busy, done, err});
    end
  endtask

  task automatic test_start_held;
    int done_n = 0;
    start = 1;
    tick;
    for (int k = 1; k <= 50; k++) begin
      eqz4_9 = (k == 11); eqz2_0 = (k == 15); eqz4_1 = (k == 17);
      tick;
      if (done) done_n++;
      if (k == 48) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", done); end
      end
      if (k == 49) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL held_idle: got busy=%b want 0", busy); end
      end
      if (k == 50) begin
        checks++;
        if ({busy, reset8, reset_reg} !== 3'b111) begin
          errors++; $display("FAIL held_second_job: got %b want 111", {busy, reset8, reset_reg});
        end
      end
    end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL held_single_job: got %0d done pulses want 1", done_n); end
    do_reset;
  endtask

  task automatic test_addr_err;
    int wr_n = 0;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k <= 20; k++) begin
      eqz4_9 = (k == 11); eqz2_0 = (k == 15); eqz4_1 = 0;
      tick;
      if (wr) wr_n++;
      if (k == 16) begin
        checks++;
        if ({wr, done, err} !== 3'b100) begin errors++; $display("FAIL addr_write2: got %b want 100", {wr, done, err}); end
      end
      if (k == 17) begin
        checks++;
        if ({done, err, busy, wr, reset8, reset_counter} !== 6'b110011) begin
          errors++; $display("FAIL addr_err_state: got %b want 110011", {done, err, busy, wr, reset8, reset_counter});
        end
      end
      if (k == 18) begin
        checks++;
        if ({done, err, busy} !== 3'b010) begin errors++; $display("FAIL err_sticky: got %b want 010", {done, err, busy}); end
      end
    end
    checks++;
    if (wr_n !== 2) begin errors++; $display("FAIL addr_wr_count: got %0d want 2", wr_n); end
    start = 1;
    tick;
    start = 0;
    checks++;
    if ({err, busy} !== 2'b01) begin errors++; $display("FAIL err_clear_on_start: got %b want 01", {err, busy}); end
    do_reset;
  endtask

  task automatic test_reset_mid;
    int done_n = 0;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k <= 13; k++) begin
      eqz4_9 = (k == 11);
      tick;
    end
    checks++;
    if ({busy, ld1} !== 2'b10) begin errors++; $display("FAIL mid_in_hash: got %b want 10", {busy, ld1}); end
    #2 reset = 0;
    #1;
    checks++;
    if ({reset8, reset4, reset_reg, reset_counter, busy, done} !== 6'b111100) begin
      errors++; $display("FAIL mid_reset_async: got %b want 111100", {reset8, reset4, reset_reg, reset_counter, busy, done});
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done) done_n++;
    end
    reset = 1;
    tick;
    if (done) done_n++;
    checks++;
    if (done_n !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_done: got done_n=%0d busy=%b want 0 0", done_n, busy);
    end
  endtask

  task automatic test_watchdog;
`ifdef SPECK_CTRL_WATCHDOG_EN
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k <= 34; k++) begin
      tick;
      if (k == 32) begin
        checks++;
        if ({busy, done, ld1} !== 3'b101) begin errors++; $display("FAIL wd_last_round: got %b want 101", {busy, done, ld1}); end
      end
      if (k == 33) begin
        checks++;
        if ({done, err, busy, reset8} !== 4'b1101) begin
          errors++; $display("FAIL wd_timeout_err: got %b want 1101", {done, err, busy, reset8});
        end
      end
    end
`else
    int bad = 0;
    start = 1;
    tick;
    start = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick;
      if (!busy || done || err) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL no_wd_wait: got %0d bad cycles want 0", bad); end
    checks++;
    if ({ld, ld1, busy} !== 3'b011) begin errors++; $display("FAIL no_wd_in_round: got %b want 011", {ld, ld1, busy}); end
`endif
    do_reset;
  endtask

  task automatic test_short;
    int wr_n = 0, rd_n = 0, done_k = -1, first_wr = -1, first_rd = -1;
    start_b = 1;
    tick;
    start_b = 0;
    for (int k = 1; k <= 22; k++) begin
      eqz4_9_b = (k == 11); eqz2_0_b = (k == 15); eqz4_1_b = 0;
      tick;
      if (wr_b) begin wr_n++; if (first_wr < 0) first_wr = k; end
      if (rd_b) begin rd_n++; if (first_rd < 0) first_rd = k; end
      if (done_b && done_k < 0) done_k = k;
    end
    eqz4_9_b = 0; eqz2_0_b = 0;
    checks++;
    if (wr_n !== 1 || rd_n !== 1) begin errors++; $display("FAIL short_counts: got wr=%0d rd=%0d want 1 1", wr_n, rd_n); end
    checks++;
    if (first_wr !== 15 || first_rd !== 17) begin
      errors++; $display("FAIL short_timing: got wr@%0d rd@%0d want 15 17", first_wr, first_rd);
    end
    checks++;
    if (done_k !== 18 || err_b !== 1'b0) begin
      errors++; $display("FAIL short_done: got done@%0d err=%b want 18 0", done_k, err_b);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_start_held;
    test_addr_err;
    test_reset_mid;
    test_watchdog;
    test_short;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
